// File: rtl/gray_world_frame_ctrl.sv
// rtl/gray_world_frame_ctrl.sv - gray-world white-balance frame sequencer (geometry check + control strobes)
// Optional error counter: define GW_FRAME_ERR_CNT_EN.
module gray_world_frame_ctrl #(
  parameter int NLINE   = 349,
  parameter int NSCREEN = 349,
  parameter int DIV_LAT = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic        acc_sof,
  output logic        eof_o,
  output logic        coef_load,
  output logic        stats_valid,
  output logic        frame_err,
  output logic        busy,
  output logic [11:0] pix_x,
  output logic [11:0] line_y,
  output logic [15:0] err_count
);

  localparam logic [0:0]  ST_IDLE   = 1'b0;
  localparam logic [0:0]  ST_ACTIVE = 1'b1;
  localparam logic [11:0] X_LAST    = 12'(NLINE - 1);
  localparam logic [11:0] Y_LAST    = 12'(NSCREEN - 1);
  localparam logic [15:0] DIV_LOAD  = 16'(DIV_LAT);

  logic [0:0]  state_q, state_d;
  logic [11:0] pix_q, pix_d;
  logic [11:0] line_q, line_d;
  logic        acc_sof_q, acc_sof_d;
  logic        eof_q, eof_d;
  logic        err_q, err_d;
  logic        coef_load_q, coef_load_d;
  logic        stats_q, stats_d;
  logic        pend_q, pend_d;
  logic [15:0] div_cnt_q, div_cnt_d;

  logic        sof_beat;
  logic        in_frame;
  logic        set_pend;
  logic [11:0] cur_x;
  logic [11:0] cur_y;

  // A SOF beat is evaluated as pixel (0,0) of a fresh frame, so the line rules apply to it too.
  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    line_d    = line_q;
    acc_sof_d = 1'b0;
    eof_d     = 1'b0;
    err_d     = 1'b0;
    sof_beat  = 1'b0;
    in_frame  = 1'b0;
    cur_x     = pix_q;
    cur_y     = line_q;

    if (s_axis_tvalid) begin
      if (s_axis_tuser) begin
        sof_beat  = 1'b1;
        acc_sof_d = 1'b1;
        err_d     = (state_q == ST_ACTIVE);
        cur_x     = 12'd0;
        cur_y     = 12'd0;
      end
      in_frame = sof_beat || (state_q == ST_ACTIVE);

      if (in_frame) begin
        state_d = ST_ACTIVE;
        if (s_axis_tlast != (cur_x == X_LAST)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
          pix_d   = 12'd0;
          line_d  = 12'd0;
        end else if (s_axis_tlast) begin
          if (cur_y == Y_LAST) begin
            eof_d   = 1'b1;
            state_d = ST_IDLE;
            pix_d   = 12'd0;
            line_d  = 12'd0;
          end else begin
            pix_d  = 12'd0;
            line_d = cur_y + 12'd1;
          end
        end else begin
          pix_d  = cur_x + 12'd1;
          line_d = cur_y;
        end
      end
    end
  end

  // Divider wait runs independently of the frame FSM; a new EOF discards any result in flight.
  always_comb begin
    div_cnt_d   = div_cnt_q;
    set_pend    = 1'b0;
    pend_d      = pend_q;
    stats_d     = stats_q;
    coef_load_d = 1'b0;

    if (div_cnt_q != 16'd0) begin
      div_cnt_d = div_cnt_q - 16'd1;
      set_pend  = (div_cnt_q == 16'd1);
    end
    if (eof_d) begin
      div_cnt_d = DIV_LOAD;
      set_pend  = (DIV_LAT == 0);
    end

    if (acc_sof_d && pend_q) begin
      coef_load_d = 1'b1;
      pend_d      = 1'b0;
      stats_d     = 1'b1;
    end
    if (set_pend) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pix_q       <= 12'd0;
      line_q      <= 12'd0;
      acc_sof_q   <= 1'b0;
      eof_q       <= 1'b0;
      err_q       <= 1'b0;
      coef_load_q <= 1'b0;
      stats_q     <= 1'b0;
      pend_q      <= 1'b0;
      div_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      line_q      <= line_d;
      acc_sof_q   <= acc_sof_d;
      eof_q       <= eof_d;
      err_q       <= err_d;
      coef_load_q <= coef_load_d;
      stats_q     <= stats_d;
      pend_q      <= pend_d;
      div_cnt_q   <= div_cnt_d;
    end
  end

`ifdef GW_FRAME_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 16'h0000;
`endif

  assign acc_sof     = acc_sof_q;
  assign eof_o       = eof_q;
  assign coef_load   = coef_load_q;
  assign stats_valid = stats_q;
  assign frame_err   = err_q;
  assign pix_x       = pix_q;
  assign line_y      = line_q;
  assign busy        = (state_q == ST_ACTIVE) || (div_cnt_q != 16'd0) || pend_q;

endmodule

// File: tb/tb_gray_world_frame_ctrl.sv
// tb/tb_gray_world_frame_ctrl.sv - randomized bench for gray_world_frame_ctrl against a frame-index reference model
module tb_gray_world_frame_ctrl;

  localparam int NLINE   = 4;
  localparam int NSCREEN = 3;
  localparam int DIV_LAT = 5;
  localparam int NPIX    = NLINE * NSCREEN;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tuser  = 1'b0;
  logic        s_axis_tlast  = 1'b0;
  logic        acc_sof, eof_o, coef_load, stats_valid, frame_err, busy;
  logic [11:0] pix_x, line_y;
  logic [15:0] err_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: frame position as a linear pixel index, divider result as an absolute ready cycle.
  bit      m_in;
  int      m_k;
  bit      m_pend;
  bit      m_stats;
  longint  m_cyc;
  longint  m_ready;
  int      m_errcnt;
  bit      e_sof, e_eof, e_err, e_load;

  gray_world_frame_ctrl #(
    .NLINE  (NLINE),
    .NSCREEN(NSCREEN),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tlast (s_axis_tlast),
    .acc_sof      (acc_sof),
    .eof_o        (eof_o),
    .coef_load    (coef_load),
    .stats_valid  (stats_valid),
    .frame_err    (frame_err),
    .busy         (busy),
    .pix_x        (pix_x),
    .line_y       (line_y),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in = 0; m_k = 0; m_pend = 0; m_stats = 0; m_ready = -1; m_errcnt = 0;
    e_sof = 0; e_eof = 0; e_err = 0; e_load = 0;
  endtask

  task automatic model_step(input bit v, input bit u, input bit l);
    bit pend_now;
    pend_now = m_pend;
    e_sof = 0; e_eof = 0; e_err = 0; e_load = 0;
    if (v) begin
      if (u) begin
        if (m_in) e_err = 1;
        m_in  = 1;
        m_k   = 0;
        e_sof = 1;
        if (pend_now) begin
          e_load  = 1;
          m_pend  = 0;
          m_stats = 1;
        end
      end
      if (m_in) begin
        if (l != ((m_k % NLINE) == NLINE - 1)) begin
          e_err = 1; m_in = 0; m_k = 0;
        end else if (m_k == NPIX - 1) begin
          e_eof = 1; m_in = 0; m_k = 0;
          m_ready = m_cyc + 1 + DIV_LAT;
        end else begin
          m_k++;
        end
      end
    end
    m_cyc++;
    if (m_cyc == m_ready) m_pend = 1;
`ifdef GW_FRAME_ERR_CNT_EN
    if (e_err && m_errcnt < 65535) m_errcnt++;
`endif
  endtask

  task automatic compare_all();
    chk("acc_sof",     acc_sof,     e_sof);
    chk("eof_o",       eof_o,       e_eof);
    chk("frame_err",   frame_err,   e_err);
    chk("coef_load",   coef_load,   e_load);
    chk("stats_valid", stats_valid, m_stats);
    chk("busy",        busy,        m_in || (m_ready > m_cyc) || m_pend);
    chk("pix_x",       pix_x,       m_k % NLINE);
    chk("line_y",      line_y,      m_k / NLINE);
    chk("err_count",   err_count,   m_errcnt);
  endtask

  task automatic step(input bit v, input bit u, input bit l);
    s_axis_tvalid = v;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    model_step(v, u, l);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1'($urandom), 1'($urandom));
  endtask

  // gap: max idle cycles before each beat (fixed if gap_fixed); errp: per-beat corruption chance in percent
  task automatic send_frame(input int gap, input bit gap_fixed, input int errp);
    bit u, l;
    for (int k = 0; k < NPIX; k++) begin
      if (gap_fixed) idle(gap);
      else idle($urandom_range(0, gap));
      u = (k == 0);
      l = ((k % NLINE) == NLINE - 1);
      if ($urandom_range(0, 99) < errp) begin
        if ($urandom_range(0, 1) == 0) l = ~l;
        else u = 1'b1;
      end
      step(1, u, l);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = 0; s_axis_tuser = 0; s_axis_tlast = 0;
    #2;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all();
  endtask

  initial begin
    m_cyc = 0;
    model_reset();
    #1;
    do_reset();

    // back-to-back clean frames, tvalid every cycle
    for (int f = 0; f < 3; f++) send_frame(0, 1, 0);
    idle(10);

    // gapped tvalid, one beat in three
    for (int f = 0; f < 2; f++) send_frame(2, 1, 0);
    idle(8);

    // short line at pix_x=2, line_y=1, then stray beats, then recovery
    for (int k = 0; k < 6; k++) step(1, k == 0, (k % NLINE) == NLINE - 1);
    step(1, 0, 1);
    for (int k = 0; k < 5; k++) step(1, 0, (k % NLINE) == NLINE - 1);
    send_frame(0, 1, 0);

    // mid-frame tuser at pix_x=2, line_y=1, frame then completes
    for (int k = 0; k < 6; k++) step(1, k == 0, (k % NLINE) == NLINE - 1);
    send_frame(0, 1, 0);
    idle(12);

    // randomized frames with gaps and corruption
    for (int f = 0; f < 30; f++) begin
      send_frame(2, 0, 8);
      idle($urandom_range(0, 8));
    end
    idle(12);

    // reset while divider countdown is at 3
    send_frame(0, 1, 0);
    idle(2);
    do_reset();
    send_frame(0, 1, 0);
    idle(DIV_LAT + 2);
    send_frame(1, 0, 0);
    send_frame(0, 1, 0);

    // three malformed frames
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 6; k++) step(1, k == 0, (k % NLINE) == NLINE - 1);
      step(1, 0, 1);
      idle(3);
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
